// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Assembles 32-bit MIPS instruction words from a symbolic operation plus
//   register/immediate/target fields and streams them into instruction memory
//   at consecutive word addresses, through a small output FIFO.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-low reset
//   flush_i      synchronous clear of FIFO and address counter
//   valid_i      operation presented on the input fields
//   ready_o      encoder accepts the operation this cycle
//   op_sel_i     operation selector (0 ADDU .. 15 JAL)
//   rs_i/rt_i/rd_i, imm_i, target_i   instruction fields
//   we_o         instruction memory write request (FIFO not empty)
//   mem_ready_i  memory accepts the write this cycle
//   addr_o       byte address of the current write
//   instr_o      instruction word of the current write (FIFO head)
//   count_o      FIFO occupancy
//   err_o        destination-is-$0 pulse (ENC_CHECK_EN builds only)
//
// Configuration
//   ENC_CHECK_EN  when defined, builds the destination-register check that
//                 drives err_o; otherwise err_o is tied to 0.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [3:0]                    op_sel_i,
    input  logic [4:0]                    rs_i,
    input  logic [4:0]                    rt_i,
    input  logic [4:0]                    rd_i,
    input  logic [15:0]                   imm_i,
    input  logic [25:0]                   target_i,
    output logic                          we_o,
    input  logic                          mem_ready_i,
    output logic [31:0]                   addr_o,
    output logic [31:0]                   instr_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Field packing for every supported operation; unused fields are zero.
    function automatic logic [31:0] encode_op(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        case (op)
            4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001}; // ADDU
            4'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011}; // SUBU
            4'd2:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100}; // AND
            4'd3:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101}; // OR
            4'd4:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010}; // SLT
            4'd5:    word = {6'b000000, rs, 15'h0000, 6'b001000};          // JR
            4'd6:    word = {6'b001000, rs, rt, imm};                      // ADDI
            4'd7:    word = {6'b001011, rs, rt, imm};                      // SLTIU
            4'd8:    word = {6'b001111, 5'b00000, rt, imm};                // LUI
            4'd9:    word = {6'b001101, rs, rt, imm};                      // ORI
            4'd10:   word = {6'b000100, rs, rt, imm};                      // BEQ
            4'd11:   word = {6'b000101, rs, rt, imm};                      // BNE
            4'd12:   word = {6'b100011, rs, rt, imm};                      // LW
            4'd13:   word = {6'b101011, rs, rt, imm};                      // SW
            4'd14:   word = {6'b000010, target};                           // J
            4'd15:   word = {6'b000011, target};                           // JAL
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      addr_q;
    logic [31:0]      last_q;   // most recently popped word, shown while empty
    logic [31:0]      enc_word_s;
    logic             ready_s, we_s, push_s, pop_s;

    assign enc_word_s = encode_op(op_sel_i, rs_i, rt_i, rd_i, imm_i, target_i);
    assign ready_s    = (count_q < DEPTH_C) && !flush_i;
    assign we_s       = (count_q != {CNT_W{1'b0}});
    assign push_s     = valid_i && ready_s;
    assign pop_s      = we_s && mem_ready_i;

    // Occupancy next state; flush wins over push and pop.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_d = count_q + ONE_C;
        end else if (pop_s && !push_s) begin
            count_d = count_q - ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage, pointers, occupancy and write address counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            addr_q   <= BASE_ADDR;
            last_q   <= 32'h0000_0000;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= {PTR_W{1'b0}};
                rd_ptr_q <= {PTR_W{1'b0}};
                addr_q   <= BASE_ADDR;
            end else begin
                if (push_s) begin
                    mem_q[wr_ptr_q] <= enc_word_s;
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_s) begin
                    last_q   <= mem_q[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    addr_q   <= addr_q + 32'd4;   // wraps modulo 2^32
                end
            end
        end
    end

    assign ready_o = ready_s;
    assign we_o    = we_s;
    assign addr_o  = addr_q;
    assign count_o = count_q;
    assign instr_o = we_s ? mem_q[rd_ptr_q] : last_q;

`ifdef ENC_CHECK_EN
    // True when the operation writes a register and that register is $0.
    function automatic logic dest_is_zero(
        input logic [3:0] op,
        input logic [4:0] rt,
        input logic [4:0] rd
    );
        logic hit;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4:  hit = (rd == 5'd0);
            4'd6, 4'd7, 4'd8, 4'd9, 4'd12: hit = (rt == 5'd0);
            default:                       hit = 1'b0;
        endcase
        return hit;
    endfunction

    logic err_q;

    // One-cycle error pulse following a push that targets $0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= push_s && dest_is_zero(op_sel_i, rt_i, rd_i);
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Reverse of the main control decoder: takes a symbolic operation plus register and immediate fields, assembles the 32-bit MIPS instruction word, and writes it into instruction memory at consecutive word addresses.
- Used by the testbench and boot-loader path to fill instruction memory before the single-cycle CPU runs.
- Input side uses a valid/ready handshake. A small FIFO separates encoding from memory write back-pressure.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first written instruction; also the value restored by flush.
- FIFO_DEPTH, 2: number of output FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous clear of the FIFO and address counter.
- valid_i  input  1  an operation is presented on the input fields.
- ready_o  output  1  the encoder can accept the operation this cycle.
- op_sel_i  input  4  operation code: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLT, 5 JR, 6 ADDI, 7 SLTIU, 8 LUI, 9 ORI, 10 BEQ, 11 BNE, 12 LW, 13 SW, 14 J, 15 JAL.
- rs_i  input  5  rs field.
- rt_i  input  5  rt field.
- rd_i  input  5  rd field.
- imm_i  input  16  immediate or branch offset.
- target_i  input  26  jump target field.
- we_o  output  1  instruction memory write request.
- mem_ready_i  input  1  instruction memory accepts the write this cycle.
- addr_o  output  32  byte address for the current write.
- instr_o  output  32  instruction word for the current write.
- count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_o  output  1  field-check error pulse; only present when ENC_CHECK_EN is defined, tied to 0 otherwise.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FIFO empty, count_o=0, we_o=0, ready_o=1.
  - addr_o=BASE_ADDR, instr_o=0, err_o=0.
- Encoding (combinational; the result is registered into the FIFO on push):
  - R-type words are {6'b000000, rs, rt, rd, 5'b0, funct} with funct ADDU=100001, SUBU=100011, AND=100100, OR=100101, SLT=101010.
  - JR is {000000, rs, 5'b0, 5'b0, 5'b0, 001000}.
  - I-type words are {opcode, rs, rt, imm} with opcodes ADDI=001000, SLTIU=001011, ORI=001101, BEQ=000100, BNE=000101, LW=100011, SW=101011.
  - LUI is {001111, 5'b0, rt, imm}; rs_i is ignored.
  - J is {000010, target} and JAL is {000011, target}.
  - Fields not used by an operation are forced to zero.
- Input handshake:
  - Push occurs when valid_i && ready_o.
  - ready_o = (count_o < FIFO_DEPTH) && !flush_i.
  - Latency: a word pushed at edge N is visible on instr_o/we_o from cycle N+1 if the FIFO was empty.
- Output handshake:
  - we_o = (count_o != 0). instr_o always shows the head entry.
  - Pop occurs when we_o && mem_ready_i; at that edge addr_o increments by 4.
  - addr_o wraps modulo 2^32 (32'hFFFF_FFFC goes to 32'h0000_0000).
  - While we_o=1 and mem_ready_i=0, instr_o and addr_o hold stable.
- Simultaneous push and pop:
  - count_o is unchanged and order is preserved.
  - When full, push is blocked even if a pop happens in the same cycle (no bypass).
- Empty FIFO: instr_o holds its last value, we_o=0.
- Flush:
  - flush_i=1 at an edge empties the FIFO, sets addr_o=BASE_ADDR and count_o=0.
  - Flush overrides any push or pop in the same cycle.
- Reset asserted mid-transfer: in-flight entries are discarded immediately and outputs return to reset values.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty are derived from count.

Optional Feature:
- Macro: ENC_CHECK_EN.
- Defined: err_o pulses for one cycle on the edge after a push whose destination register is $0:
  - rd_i=0 for ADDU/SUBU/AND/OR/SLT;
  - rt_i=0 for ADDI/SLTIU/LUI/ORI/LW.
  - The word is still encoded and written unchanged.
- Not defined: no check logic is built and err_o is tied to 0.

Test Plan:
- Reset, then push ADDU with rs=1, rt=2, rd=3 while mem_ready_i=1 → next cycle we_o=1, instr_o=32'h0022_1821, addr_o=0; the following cycle addr_o=4.
- Push ADDI rs=0, rt=8, imm=16'hFFFF, then BEQ rs=8, rt=9, imm=16'h0003, then J target=26'h0000010 → words 32'h2008_FFFF, 32'h1109_0003, 32'h0800_0010 at addresses 0, 4, 8.
- Hold mem_ready_i=0 and push 3 ops with FIFO_DEPTH=2 → ready_o drops after 2 pushes, count_o=2, instr_o/addr_o stable; raise mem_ready_i → the third op is accepted and all 3 written in order.
- Set BASE_ADDR=32'hFFFF_FFFC and push 2 LUI ops (rt=5, imm=16'h1234) → writes 32'h3C05_1234 at 32'hFFFF_FFFC, then at 32'h0000_0000.
- With 2 entries queued, assert flush_i together with valid_i → count_o=0, addr_o=BASE_ADDR, push ignored; separately, pulse rst_i low mid-write → we_o=0 immediately.
- With ENC_CHECK_EN defined, push ORI with rt=0 → err_o=1 for exactly one cycle and the word 32'h3400_xxxx is still written; without the macro, err_o stays 0.
